// File: rtl/leaf_out_stream_buffer_if.sv
// Handshake bundle between a user-kernel output stream, the elastic buffer
// and one user2interface input port of the leaf interface.
// The slave modport is the buffer's view. The master modport is the
// environment's view: the user kernel on one side and the leaf interface on
// the other.
interface leaf_out_stream_buffer_if #(
  parameter int PAYLOAD_BITS = 32
) ();

  // User-kernel side.
  logic [PAYLOAD_BITS-1:0] din_user;
  logic                    vld_user_in;
  logic                    rdy_user_out;

  // Leaf-interface side.
  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic                    vld_user2interface;
  logic                    ack_interface2user;

  modport slave (
    input  din_user,
    input  vld_user_in,
    output rdy_user_out,
    output din_leaf_user2interface,
    output vld_user2interface,
    input  ack_interface2user
  );

  modport master (
    output din_user,
    output vld_user_in,
    input  rdy_user_out,
    input  din_leaf_user2interface,
    input  vld_user2interface,
    output ack_interface2user
  );

endinterface

// File: rtl/leaf_out_stream_buffer.sv
// Elastic buffer between one user-kernel output stream and one leaf-interface
// input port. It has a circular RAM, a registered first-word-fall-through
// output stage, and debug counters for occupancy and delivered words.
// Everything runs on clk_user. reset is asynchronous and active-low.
module leaf_out_stream_buffer #(
  parameter int PAYLOAD_BITS       = 32,
  parameter int DEPTH_BITS         = 4,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input  logic                  clk_user,
  input  logic                  reset,
  leaf_out_stream_buffer_if.slave bus,
  output logic [DEPTH_BITS:0]   count,
  output logic                  almost_full,
  output logic [31:0]           xfer_count
);

  localparam int                DEPTH      = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] AF_COUNT   = (DEPTH_BITS + 1)'(ALMOST_FULL_THRESH);

  // Storage and pointers.
  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [DEPTH_BITS-1:0]   wr_ptr;
  logic [DEPTH_BITS-1:0]   rd_ptr;
  logic [DEPTH_BITS-1:0]   rd_ptr_nxt;

  // Handshake and bookkeeping.
  logic                    live;
  logic                    rdy;
  logic                    push;
  logic                    pop;
  logic [DEPTH_BITS:0]     count_nxt;
  logic [DEPTH_BITS:0]     avail;

  // Output register stage.
  logic                    vld_q;
  logic [PAYLOAD_BITS-1:0] dout_q;

  // live holds the input closed until the first edge after reset is released.
  // A full buffer refuses a push even when a pop happens in the same cycle.
  assign rdy  = live & (count != FULL_COUNT);
  assign push = bus.vld_user_in & rdy;
  assign pop  = vld_q & bus.ack_interface2user;

  assign bus.rdy_user_out            = rdy;
  assign bus.vld_user2interface      = vld_q;
  assign bus.din_leaf_user2interface = dout_q;

  // Next-occupancy and output-stage lookahead.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave a value
    // held and infer a latch.
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr + DEPTH_BITS'(pop);
    // avail counts the words already in the RAM before this edge that are
    // still there after it. A word pushed on this same edge is not yet
    // readable, which gives the one-cycle fall-through latency.
    avail      = count - (DEPTH_BITS + 1)'(pop);
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // RAM write port.
  // NOTE: the storage array has no reset. Words that are in flight when reset
  // arrives are discarded through the pointers and count, so clearing the
  // array would add logic without changing any observable behaviour.
  always_ff @(posedge clk_user) begin
    if (push) begin
      mem[wr_ptr] <= bus.din_user;
    end
  end

  // Pointers, occupancy, almost_full and the delivered-word counter.
  always_ff @(posedge clk_user or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge.
    if (!reset) begin
      live        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      xfer_count  <= '0;
    end else begin
      live <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      almost_full <= (count_nxt >= AF_COUNT);
      if (pop) begin
        xfer_count <= xfer_count + 32'd1;
      end
    end
  end

  // Registered first-word-fall-through output.
  // The stage reloads from the entry at the post-pop read pointer on every
  // edge, so a pop with more words queued presents the next word with no
  // bubble. While the output is stalled the same entry is reloaded, and that
  // entry cannot be overwritten: the write pointer meets the read pointer
  // only when the buffer is empty or full, and a full buffer accepts no push.
  always_ff @(posedge clk_user or negedge reset) begin
    if (!reset) begin
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      vld_q <= (avail != '0);
      if (avail != '0) begin
        dout_q <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: tb/tb_leaf_out_stream_buffer.sv
// Self-checking bench for leaf_out_stream_buffer.
// The driver enqueues each accepted word as an expected value. A separate
// monitor pops the queue and compares on every delivery (vld & ack).
// Status outputs are checked directly against hand-computed values.
module tb_leaf_out_stream_buffer;

  localparam int PB  = 32;
  localparam int DB  = 4;
  localparam int AFT = 12;

  logic          clk_user = 1'b0;
  logic          reset    = 1'b1;
  logic [DB:0]   count;
  logic          almost_full;
  logic [31:0]   xfer_count;

  leaf_out_stream_buffer_if #(.PAYLOAD_BITS(PB)) bus ();

  leaf_out_stream_buffer #(
    .PAYLOAD_BITS      (PB),
    .DEPTH_BITS        (DB),
    .ALMOST_FULL_THRESH(AFT)
  ) dut (
    .clk_user   (clk_user),
    .reset      (reset),
    .bus        (bus),
    .count      (count),
    .almost_full(almost_full),
    .xfer_count (xfer_count)
  );

  always #5 clk_user = ~clk_user;

  int            errors = 0;
  int            checks = 0;
  logic [PB-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a delivery happens at the next rising edge.
  always @(negedge clk_user) begin
    if (reset && bus.vld_user2interface && bus.ack_interface2user) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got word %0h with nothing expected", bus.din_leaf_user2interface);
      end else begin
        logic [PB-1:0] e;
        e = exp_q.pop_front();
        check("sb_data", bus.din_leaf_user2interface, e);
      end
    end
  end

  // One clock of stimulus. Inputs change 1 time unit after the rising edge.
  // pushed reports whether the word was accepted at that edge.
  task automatic cycle(input logic v, input logic [PB-1:0] d, input logic a, output logic pushed);
    bus.vld_user_in        = v;
    bus.din_user           = d;
    bus.ack_interface2user = a;
    @(negedge clk_user);
    pushed = v && bus.rdy_user_out && reset;
    if (pushed) exp_q.push_back(d);
    @(posedge clk_user);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    bus.vld_user_in        = 1'b0;
    bus.ack_interface2user = 1'b1;
    while (count != 0 && n < budget) begin
      @(posedge clk_user);
      #1;
      n++;
    end
    bus.ack_interface2user = 1'b0;
    check("drain_done", count, 0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bus.rdy_user_out, bus.vld_user2interface, bus.din_leaf_user2interface,
                 count, almost_full, xfer_count}, '0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       p;
    int         pushed_n;
    int         cyc;
    logic [DB:0] max_cnt;

    bus.din_user           = '0;
    bus.vld_user_in        = 1'b0;
    bus.ack_interface2user = 1'b0;
    #1 reset = 1'b0;

    // Outputs stay at zero while reset is held, whatever the inputs do.
    for (int i = 0; i < 4; i++) begin
      bus.vld_user_in        = 1'($urandom_range(0, 1));
      bus.ack_interface2user = 1'($urandom_range(0, 1));
      bus.din_user           = $urandom;
      @(negedge clk_user);
      check_all_zero("reset_hold");
    end

    // Release between edges; rdy rises only after the next edge.
    @(posedge clk_user);
    #1;
    bus.vld_user_in        = 1'b0;
    bus.ack_interface2user = 1'b0;
    reset                  = 1'b1;
    #1;
    check("rdy_before_edge", bus.rdy_user_out, 0);
    @(posedge clk_user);
    #1;
    check("rdy_after_release", bus.rdy_user_out, 1);
    check("count_after_release", count, 0);

    // One word, one-cycle latency, held stable while ack is low.
    cycle(1'b1, 32'hDEADBEEF, 1'b0, p);
    check("single_accept", p, 1);
    check("single_vld_latency", bus.vld_user2interface, 0);
    check("single_count", count, 1);
    cycle(1'b0, '0, 1'b0, p);
    check("single_vld", bus.vld_user2interface, 1);
    check("single_data", bus.din_leaf_user2interface, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b0, p);
      check("single_hold", {bus.vld_user2interface, bus.din_leaf_user2interface, count},
            {1'b1, 32'hDEADBEEF, 5'd1});
    end
    cycle(1'b0, '0, 1'b1, p);
    check("single_vld_after_ack", bus.vld_user2interface, 0);
    check("single_count_after_ack", count, 0);
    check("single_xfer", xfer_count, 1);

    // Fill to 16 with ack low; almost_full rises when count reaches 12.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, PB'(i), 1'b0, p);
      check("fill_count", count, i + 1);
      check("fill_almost_full", almost_full, (i + 1) >= AFT);
    end
    check("full_rdy_low", bus.rdy_user_out, 0);
    cycle(1'b1, 32'd99, 1'b0, p);
    check("full_push_refused", count, 16);

    // Full with a push and a pop offered together: only the pop happens.
    cycle(1'b1, 32'd100, 1'b1, p);
    check("full_pop_only_count", count, 15);
    check("full_rdy_back", bus.rdy_user_out, 1);
    drain(64);
    check("fill_xfer", xfer_count, 17);           // 1 + 16 words
    check("drained_almost_full", almost_full, 0);

    // Streaming with both sides ready: every push accepted, steady count of 2.
    for (int w = 16; w <= 40; w++) begin
      cycle(1'b1, PB'(w), 1'b1, p);
      check("stream_accept", p, 1);
    end
    check("stream_throughput_count", count, 2);
    drain(64);
    check("stream_xfer", xfer_count, 42);         // 1 + 16 + 25 words

    // Random back-pressure.
    pushed_n = 0;
    cyc      = 0;
    max_cnt  = '0;
    while (pushed_n < 10000 && cyc < 60000) begin
      cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 3), p);
      if (p) pushed_n++;
      if (count > max_cnt) max_cnt = count;
      cyc++;
    end
    check("random_all_pushed", pushed_n, 10000);
    check("random_count_bound", (max_cnt <= 16), 1);
    drain(200);
    check("random_sb_empty", exp_q.size(), 0);
    check("random_xfer", xfer_count, 10042);

    // Reset in the middle of a stream, asserted between edges.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 32'hA000 + PB'(i), 1'b0, p);
    end
    check("mid_count", count, 7);
    check("mid_vld", bus.vld_user2interface, 1);
    bus.vld_user_in        = 1'b0;
    bus.ack_interface2user = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset_async");
    exp_q.delete();
    repeat (2) @(posedge clk_user);
    #1;
    reset = 1'b1;
    @(posedge clk_user);
    #1;
    cycle(1'b1, 32'h1, 1'b0, p);
    check("post_reset_accept", p, 1);
    cycle(1'b0, '0, 1'b0, p);
    check("post_reset_data", {bus.vld_user2interface, bus.din_leaf_user2interface}, {1'b1, 32'h1});
    cycle(1'b0, '0, 1'b1, p);
    check("post_reset_xfer", xfer_count, 1);
    check("post_reset_empty", {bus.vld_user2interface, count}, '0);
    check("post_reset_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
